// File: rtl/fe_frame_builder.sv
// rtl/fe_frame_builder.sv - frames 24-bit upstream records into SOF / 3 data bytes per record / EOF symbols
module fe_frame_builder #(
  parameter int         WORDS_PER_FRAME = 4,
  parameter logic [7:0] K_IDLE          = 8'h3C,
  parameter logic [7:0] K_SOF           = 8'hFC,
  parameter logic [7:0] K_EOF           = 8'hBC
) (
  input  logic        clkread,
  input  logic        reset_n,
  input  logic        data_rdy,
  input  logic [23:0] din,
  output logic        read,
  input  logic        byte_en,
  output logic [7:0]  byte_out,
  output logic        k_out,
  output logic        frame_active,
  output logic [7:0]  word_cnt
);

  localparam logic [7:0] MAX_CNT = 8'(WORDS_PER_FRAME);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_B1,
    ST_B2,
    ST_B3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic        k_q, k_d;
  logic        read_q, read_d;
  logic        latch_q, latch_d;
  logic        fetched_q, fetched_d;
  logic        fa_q, fa_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [23:0] wbuf_q, wbuf_d;
  logic [7:0]  cnt_inc;

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    k_d       = k_q;
    read_d    = 1'b0;
    fetched_d = fetched_q;
    fa_d      = fa_q;
    cnt_d     = cnt_q;
    cnt_inc   = (cnt_q < MAX_CNT) ? cnt_q + 8'd1 : cnt_q;
    // upstream presents din one cycle after read; capture it one cycle later still
    latch_d   = read_q;
    wbuf_d    = latch_q ? din : wbuf_q;

    if (byte_en) begin
      case (state_q)
        ST_IDLE: begin
          k_d = 1'b1;
          if (data_rdy) begin
            byte_d    = K_SOF;
            fa_d      = 1'b1;
            cnt_d     = 8'd0;
            read_d    = 1'b1;
            fetched_d = 1'b1;
            state_d   = ST_SOF;
          end else begin
            byte_d = K_IDLE;
            fa_d   = 1'b0;
          end
        end
        ST_SOF, ST_B3: begin
          if (state_q == ST_SOF || (fetched_q && data_rdy && cnt_q < MAX_CNT)) begin
            byte_d  = wbuf_q[23:16];
            k_d     = 1'b0;
            state_d = ST_B1;
          end else begin
            // frame_active stays high through the EOF symbol and drops on the next strobe
            byte_d  = K_EOF;
            k_d     = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_B1: begin
          byte_d  = wbuf_q[15:8];
          k_d     = 1'b0;
          state_d = ST_B2;
        end
        ST_B2: begin
          byte_d    = wbuf_q[7:0];
          k_d       = 1'b0;
          cnt_d     = cnt_inc;
          read_d    = data_rdy && (cnt_inc < MAX_CNT);
          fetched_d = read_d;
          state_d   = ST_B3;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clkread or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      byte_q    <= K_IDLE;
      k_q       <= 1'b1;
      read_q    <= 1'b0;
      latch_q   <= 1'b0;
      fetched_q <= 1'b0;
      fa_q      <= 1'b0;
      cnt_q     <= 8'd0;
      wbuf_q    <= 24'd0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      k_q       <= k_d;
      read_q    <= read_d;
      latch_q   <= latch_d;
      fetched_q <= fetched_d;
      fa_q      <= fa_d;
      cnt_q     <= cnt_d;
      wbuf_q    <= wbuf_d;
    end
  end

  assign read         = read_q;
  assign byte_out     = byte_q;
  assign k_out        = k_q;
  assign frame_active = fa_q;
  assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_fe_frame_builder.sv
// tb/tb_fe_frame_builder.sv - directed bench for fe_frame_builder with a 4-record upstream model
module tb_fe_frame_builder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_rdy = 1'b0;
  logic        byte_en = 1'b0;

  logic [23:0] din0, din1;
  logic        read0, read1;
  logic [7:0]  byte0, byte1, wcnt0, wcnt1;
  logic        k0, k1, fa0, fa1;

  int checks = 0;
  int failures = 0;
  int rd_cnt0, rd_cnt1, idx0, idx1;

  logic [23:0] rom [4];
  logic [7:0]  exp_full [15];
  logic [7:0]  exp_eof  [9];
  logic [7:0]  exp_one  [10];

  always #5 clk = ~clk;

  fe_frame_builder #(.WORDS_PER_FRAME(4)) dut (
    .clkread(clk), .reset_n(reset_n), .data_rdy(data_rdy), .din(din0), .read(read0),
    .byte_en(byte_en), .byte_out(byte0), .k_out(k0), .frame_active(fa0), .word_cnt(wcnt0)
  );

  fe_frame_builder #(.WORDS_PER_FRAME(1)) dut1 (
    .clkread(clk), .reset_n(reset_n), .data_rdy(data_rdy), .din(din1), .read(read1),
    .byte_en(byte_en), .byte_out(byte1), .k_out(k1), .frame_active(fa1), .word_cnt(wcnt1)
  );

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din0 <= 24'd0; idx0 <= 0; rd_cnt0 <= 0;
    end else if (read0) begin
      din0 <= rom[idx0 % 4]; idx0 <= idx0 + 1; rd_cnt0 <= rd_cnt0 + 1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din1 <= 24'd0; idx1 <= 0; rd_cnt1 <= 0;
    end else if (read1) begin
      din1 <= rom[idx1 % 4]; idx1 <= idx1 + 1; rd_cnt1 <= rd_cnt1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_k(input logic [7:0] b);
    return (b == 8'hFC) || (b == 8'hBC) || (b == 8'h3C);
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic strobe(input int gap);
    byte_en = 1'b1;
    @(negedge clk);
    byte_en = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic run_full(input int gap, input string tag);
    for (int i = 0; i < 15; i++) begin
      strobe(gap);
      check($sformatf("%s_byte%0d", tag, i), byte0, exp_full[i]);
      check($sformatf("%s_k%0d", tag, i), k0, is_k(exp_full[i]));
      if (i == 13) begin
        check({tag, "_reads_frame"}, rd_cnt0, 4);
        check({tag, "_wcnt_eof"}, wcnt0, 4);
        check({tag, "_fa_eof"}, fa0, 1);
      end
    end
  endtask

  initial begin
    rom[0] = 24'hA1B2C3; rom[1] = 24'h112233; rom[2] = 24'h445566; rom[3] = 24'h778899;
    exp_full = '{8'hFC, 8'hA1, 8'hB2, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hBC, 8'hFC};
    exp_eof  = '{8'hFC, 8'hA1, 8'hB2, 8'hC3, 8'h11, 8'h22, 8'h33, 8'hBC, 8'h3C};
    exp_one  = '{8'hFC, 8'hA1, 8'hB2, 8'hC3, 8'hBC, 8'hFC, 8'h11, 8'h22, 8'h33, 8'hBC};

    // 1: reset values, idle with no data
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_byte", byte0, 8'h3C);
    check("rst_k", k0, 1);
    check("rst_read", read0, 0);
    check("rst_fa", fa0, 0);
    check("rst_wcnt", wcnt0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(10);
      check($sformatf("idle_byte%0d", i), byte0, 8'h3C);
      check($sformatf("idle_k%0d", i), k0, 1);
    end
    check("idle_reads", rd_cnt0, 0);

    // 2: full frame, spacing 4
    data_rdy = 1'b1;
    do_reset();
    run_full(4, "full4");
    check("full4_reads_next", rd_cnt0, 5);

    // 3: data_rdy drops before the second record's last byte
    do_reset();
    for (int i = 0; i < 9; i++) begin
      strobe(4);
      check($sformatf("eof_byte%0d", i), byte0, exp_eof[i]);
      check($sformatf("eof_k%0d", i), k0, is_k(exp_eof[i]));
      if (i == 5) data_rdy = 1'b0;
      if (i == 7) begin
        check("eof_wcnt", wcnt0, 2);
        check("eof_fa_at_bc", fa0, 1);
      end
    end
    check("eof_fa_idle", fa0, 0);
    check("eof_reads", rd_cnt0, 2);

    // 4: one record per frame
    data_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      strobe(4);
      check($sformatf("one_byte%0d", i), byte1, exp_one[i]);
      check($sformatf("one_k%0d", i), k1, is_k(exp_one[i]));
      check($sformatf("one_fa%0d", i), fa1, 1);
      if (i == 9) data_rdy = 1'b0;
    end
    strobe(4);
    check("one_idle_byte", byte1, 8'h3C);
    check("one_idle_fa", fa1, 0);
    check("one_reads", rd_cnt1, 2);
    check("one_wcnt", wcnt1, 1);

    // 5: async reset in the middle of a frame
    data_rdy = 1'b1;
    do_reset();
    strobe(4);
    strobe(4);
    check("mid_pre_byte", byte0, 8'hA1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_async_byte", byte0, 8'h3C);
    check("mid_async_k", k0, 1);
    check("mid_async_read", read0, 0);
    check("mid_async_fa", fa0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      strobe(4);
      check($sformatf("mid_restart%0d", i), byte0, exp_full[i]);
    end

    // 6: minimum strobe spacing
    do_reset();
    run_full(3, "full3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
